// File: rtl/id_stage.sv
// RV32I decode stage: register file, immediate and control decode,
// load-use hazard detection, and the ID/EX pipeline register.
package pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
    } if_id_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        a_pc;
        logic        b_imm;
        logic [2:0]  funct3;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
        logic        branch;
        logic        jump;
        logic        illegal;
    } id_ex_t;

endpackage

module id_stage
    import pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  if_id_t          in,
    input  logic            en,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall_o,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_alu_op,
    output logic            ex_a_pc,
    output logic            ex_b_imm,
    output logic [2:0]      ex_funct3,
    output logic            ex_mem_rd,
    output logic            ex_mem_wr,
    output logic            ex_reg_wr,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_illegal
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_FENCE = 7'b0001111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [6:0] F7_ALT = 7'b0100000;

    logic [XLEN-1:0] r_rf [32];
    id_ex_t          r_ex;

    logic [31:0]     w_ins;
    logic [6:0]      w_op;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [31:0]     w_imm_i;
    logic [31:0]     w_imm_s;
    logic [31:0]     w_imm_b;
    logic [31:0]     w_imm_u;
    logic [31:0]     w_imm_j;
    logic [3:0]      w_base;
    logic            w_use1;
    logic            w_use2;
    logic            w_hasrd;
    logic            w_ill;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    id_ex_t          w_dec;
    id_ex_t          w_nxt;
    logic            w_load;

    assign w_ins = in.instr;
    assign w_op  = w_ins[6:0];
    assign w_f3  = w_ins[14:12];
    assign w_f7  = w_ins[31:25];

    assign w_imm_i = {{20{w_ins[31]}}, w_ins[31:20]};
    assign w_imm_s = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
    assign w_imm_b = {{19{w_ins[31]}}, w_ins[31], w_ins[7],
                      w_ins[30:25], w_ins[11:8], 1'b0};
    assign w_imm_u = {w_ins[31:12], 12'b0};
    assign w_imm_j = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12],
                      w_ins[20], w_ins[30:21], 1'b0};

    // funct3 -> ALU op for the unmodified OP / OP-IMM encodings
    always_comb begin
        unique case (w_f3)
            3'd0:    w_base = 4'd0;
            3'd1:    w_base = 4'd2;
            3'd2:    w_base = 4'd3;
            3'd3:    w_base = 4'd4;
            3'd4:    w_base = 4'd5;
            3'd5:    w_base = 4'd6;
            3'd6:    w_base = 4'd8;
            default: w_base = 4'd9;
        endcase
    end

    // opcode decode into control bits, immediate and operand usage
    always_comb begin
        w_dec        = '0;
        w_use1       = 1'b0;
        w_use2       = 1'b0;
        w_hasrd      = 1'b0;
        w_ill        = 1'b0;
        w_dec.valid  = 1'b1;
        w_dec.pc     = in.pc;
        w_dec.funct3 = w_f3;
        unique case (w_op)
            OP_LUI: begin
                w_hasrd       = 1'b1;
                w_dec.imm     = w_imm_u;
                w_dec.alu_op  = ALU_PASSB;
                w_dec.b_imm   = 1'b1;
                w_dec.reg_wr  = 1'b1;
            end
            OP_AUIPC: begin
                w_hasrd       = 1'b1;
                w_dec.imm     = w_imm_u;
                w_dec.a_pc    = 1'b1;
                w_dec.b_imm   = 1'b1;
                w_dec.reg_wr  = 1'b1;
            end
            OP_JAL: begin
                w_hasrd       = 1'b1;
                w_dec.imm     = w_imm_j;
                w_dec.a_pc    = 1'b1;
                w_dec.jump    = 1'b1;
                w_dec.reg_wr  = 1'b1;
            end
            OP_JALR: begin
                w_hasrd       = 1'b1;
                w_use1        = 1'b1;
                w_dec.imm     = w_imm_i;
                w_dec.a_pc    = 1'b1;
                w_dec.jump    = 1'b1;
                w_dec.reg_wr  = 1'b1;
            end
            OP_BR: begin
                w_use1        = 1'b1;
                w_use2        = 1'b1;
                w_dec.imm     = w_imm_b;
                w_dec.alu_op  = ALU_SUB;
                w_dec.branch  = 1'b1;
            end
            OP_LOAD: begin
                w_hasrd       = 1'b1;
                w_use1        = 1'b1;
                w_dec.imm     = w_imm_i;
                w_dec.b_imm   = 1'b1;
                w_dec.mem_rd  = 1'b1;
                w_dec.reg_wr  = 1'b1;
            end
            OP_STORE: begin
                w_use1        = 1'b1;
                w_use2        = 1'b1;
                w_dec.imm     = w_imm_s;
                w_dec.b_imm   = 1'b1;
                w_dec.mem_wr  = 1'b1;
            end
            OP_IMM: begin
                w_hasrd       = 1'b1;
                w_use1        = 1'b1;
                w_dec.imm     = w_imm_i;
                w_dec.b_imm   = 1'b1;
                w_dec.reg_wr  = 1'b1;
                w_dec.alu_op  = (w_f3 == 3'd5 && w_f7 == F7_ALT)
                              ? ALU_SRA : w_base;
                if (w_f3 == 3'd1)
                    w_ill = (w_f7 != 7'd0);
                else if (w_f3 == 3'd5)
                    w_ill = (w_f7 != 7'd0) && (w_f7 != F7_ALT);
            end
            OP_REG: begin
                w_hasrd       = 1'b1;
                w_use1        = 1'b1;
                w_use2        = 1'b1;
                w_dec.reg_wr  = 1'b1;
                w_dec.alu_op  = w_base;
                if (w_f7 == F7_ALT && w_f3 == 3'd0)
                    w_dec.alu_op = ALU_SUB;
                else if (w_f7 == F7_ALT && w_f3 == 3'd5)
                    w_dec.alu_op = ALU_SRA;
                else if (w_f7 != 7'd0)
                    w_ill = 1'b1;
            end
            OP_FENCE, OP_SYS: ;
            default: w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_dec         = '0;
            w_dec.valid   = 1'b1;
            w_dec.pc      = in.pc;
            w_dec.funct3  = w_f3;
            w_dec.illegal = 1'b1;
            w_use1        = 1'b0;
            w_use2        = 1'b0;
            w_hasrd       = 1'b0;
        end
    end

    assign w_rs1 = w_use1 ? w_ins[19:15] : 5'd0;
    assign w_rs2 = w_use2 ? w_ins[24:20] : 5'd0;

    assign w_rs1_val = (w_rs1 == 5'd0) ? '0
                     : (wb_we && wb_rd == w_rs1) ? wb_data
                     : r_rf[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? '0
                     : (wb_we && wb_rd == w_rs2) ? wb_data
                     : r_rf[w_rs2];

    // attach register indices and operand values to the decoded bundle
    always_comb begin
        w_nxt         = w_dec;
        w_nxt.rs1     = w_rs1;
        w_nxt.rs2     = w_rs2;
        w_nxt.rd      = w_hasrd ? w_ins[11:7] : 5'd0;
        w_nxt.rs1_val = w_rs1_val;
        w_nxt.rs2_val = w_rs2_val;
    end

    assign stall_o = r_ex.valid & r_ex.mem_rd & (r_ex.rd != 5'd0)
                   & in.valid
                   & ((w_use1 & (w_rs1 == r_ex.rd))
                    | (w_use2 & (w_rs2 == r_ex.rd)));

    assign w_load = in.valid & ~stall_o;

    // register file write port; x0 is never written
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)
                r_rf[i] <= '0;
        end else if (wb_we && wb_rd != 5'd0) begin
            r_rf[wb_rd] <= wb_data;
        end
    end

    // ID/EX register: reset, then flush, then hold, then bubble or load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex    <= '0;
            r_ex.pc <= RESET_PC;
        end else if (flush) begin
            r_ex <= '0;
        end else if (en) begin
            r_ex <= w_load ? w_nxt : '0;
        end
    end

    assign ex_valid   = r_ex.valid;
    assign ex_pc      = r_ex.pc;
    assign ex_rs1_val = r_ex.rs1_val;
    assign ex_rs2_val = r_ex.rs2_val;
    assign ex_imm     = r_ex.imm;
    assign ex_rs1     = r_ex.rs1;
    assign ex_rs2     = r_ex.rs2;
    assign ex_rd      = r_ex.rd;
    assign ex_alu_op  = r_ex.alu_op;
    assign ex_a_pc    = r_ex.a_pc;
    assign ex_b_imm   = r_ex.b_imm;
    assign ex_funct3  = r_ex.funct3;
    assign ex_mem_rd  = r_ex.mem_rd;
    assign ex_mem_wr  = r_ex.mem_wr;
    assign ex_reg_wr  = r_ex.reg_wr;
    assign ex_branch  = r_ex.branch;
    assign ex_jump    = r_ex.jump;
    assign ex_illegal = r_ex.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage: decode table plus
// hand-written hazard, flush, hold and reset sequences.
module tb_id_stage;
    import pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic [7:0]  fl;
    } out_t;

    typedef struct {
        logic [31:0] instr;
        logic        wbe;
        logic [4:0]  wbr;
        logic [31:0] wbd;
        logic        full;
        logic        has_imm;
        out_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    if_id_t      din;
    logic        en, flush, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall_o, ex_valid;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_alu_op;
    logic [2:0]  ex_funct3;
    logic        ex_a_pc, ex_b_imm, ex_mem_rd, ex_mem_wr;
    logic        ex_reg_wr, ex_branch, ex_jump, ex_illegal;
    out_t        act;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vt [16];

    always #5 clk = ~clk;

    id_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .in(din), .en(en), .flush(flush),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_o(stall_o), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_a_pc(ex_a_pc),
        .ex_b_imm(ex_b_imm), .ex_funct3(ex_funct3),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ex_reg_wr(ex_reg_wr), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_illegal(ex_illegal)
    );

    // flags: a_pc b_imm mem_rd mem_wr reg_wr branch jump illegal
    always_comb begin
        act = {ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_alu_op,
               ex_a_pc, ex_b_imm, ex_mem_rd, ex_mem_wr,
               ex_reg_wr, ex_branch, ex_jump, ex_illegal};
    end

    function automatic out_t mk(
        input logic [31:0] pc, input logic [31:0] r1v,
        input logic [31:0] r2v, input logic [31:0] imm,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic [4:0] rd, input logic [3:0] alu,
        input logic [7:0] fl);
        out_t o;
        o = '{1'b1, pc, r1v, r2v, imm, r1, r2, rd, alu, fl};
        return o;
    endfunction

    function automatic vec_t vf(
        input logic [31:0] ins, input logic wbe,
        input logic [4:0] wbr, input logic [31:0] wbd,
        input logic hi, input out_t e);
        vec_t v;
        v.instr = ins; v.wbe = wbe; v.wbr = wbr; v.wbd = wbd;
        v.full = 1'b1; v.has_imm = hi; v.exp = e;
        return v;
    endfunction

    function automatic vec_t vc(
        input logic [31:0] ins, input logic [31:0] pc,
        input logic [7:0] fl);
        vec_t v;
        v.instr = ins; v.wbe = 1'b0; v.wbr = '0; v.wbd = '0;
        v.full = 1'b0; v.has_imm = 1'b0;
        v.exp = mk(pc, 0, 0, 0, 0, 0, 0, 0, fl);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic [31:0] pc);
        din.valid = v;
        din.instr = ins;
        din.pc    = pc;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        automatic logic [31:0] P = 32'h0000_1000;
        automatic out_t a, e;
        automatic logic ok;

        vt[0]  = vf(32'h123450B7, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1,
                    mk(P+0,  0, 0, 32'h12345000, 0, 0, 1, 10, 8'h48));
        vt[1]  = vf(32'h00028333, 1'b0, 5'd0, 32'h0, 1'b0,
                    mk(P+4,  32'hDEADBEEF, 0, 0, 5, 0, 6, 0, 8'h08));
        vt[2]  = vf(32'hFFF38413, 1'b1, 5'd7, 32'h1234, 1'b1,
                    mk(P+8,  32'h1234, 0, 32'hFFFFFFFF, 7, 0, 8, 0, 8'h48));
        vt[3]  = vf(32'h405385B3, 1'b0, 5'd0, 32'h0, 1'b0,
                    mk(P+12, 32'h1234, 32'hDEADBEEF, 0, 7, 5, 11, 1, 8'h08));
        vt[4]  = vf(32'h4072D633, 1'b0, 5'd0, 32'h0, 1'b0,
                    mk(P+16, 32'hDEADBEEF, 32'h1234, 0, 5, 7, 12, 7, 8'h08));
        vt[5]  = vf(32'h4042D693, 1'b0, 5'd0, 32'h0, 1'b1,
                    mk(P+20, 32'hDEADBEEF, 0, 32'h404, 5, 0, 13, 7, 8'h48));
        vt[6]  = vf(32'hFFF2C213, 1'b0, 5'd0, 32'h0, 1'b1,
                    mk(P+24, 32'hDEADBEEF, 0, 32'hFFFFFFFF, 5, 0, 4, 5, 8'h48));
        vt[7]  = vc(32'h40329713, P+28, 8'h01);
        vt[8]  = vc(32'h02000033, P+32, 8'h01);
        vt[9]  = vf(32'h0053A623, 1'b0, 5'd0, 32'h0, 1'b1,
                    mk(P+36, 32'h1234, 32'hDEADBEEF, 12, 7, 5, 0, 0, 8'h50));
        vt[10] = vf(32'hFFDFF0EF, 1'b0, 5'd0, 32'h0, 1'b1,
                    mk(P+40, 0, 0, 32'hFFFFFFFC, 0, 0, 1, 0, 8'h8A));
        vt[11] = vf(32'h008280E7, 1'b0, 5'd0, 32'h0, 1'b1,
                    mk(P+44, 32'hDEADBEEF, 0, 8, 5, 0, 1, 0, 8'h8A));
        vt[12] = vf(32'h00001197, 1'b0, 5'd0, 32'h0, 1'b1,
                    mk(P+48, 0, 0, 32'h1000, 0, 0, 3, 0, 8'hC8));
        vt[13] = vc(32'hFFFFFFFF, P+52, 8'h01);
        vt[14] = vc(32'h0FF0000F, P+56, 8'h00);
        vt[15] = vc(32'h00000073, P+60, 8'h00);

        rst_n = 1'b0; en = 1'b1; flush = 1'b0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        drive(1'b1, 32'h00028333, 32'h0000_0040);
        tick; tick;
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_pc", ex_pc, RST_PC);
        chk("rst_flags", {24'd0, act.fl}, 32'd0);
        rst_n = 1'b1;

        for (int i = 1; i < 32; i++) begin
            drive(1'b1, (32'(i) << 20) | (32'(i) << 15) | 32'h0000_00B3,
                  32'h0000_0200);
            tick;
            chk($sformatf("rf_zero_x%0d", i),
                ex_rs1_val | ex_rs2_val | {31'd0, ~ex_valid}, 32'd0);
        end

        for (int i = 0; i < 16; i++) begin
            drive(1'b1, vt[i].instr, P + 32'(i) * 4);
            wb_we = vt[i].wbe; wb_rd = vt[i].wbr; wb_data = vt[i].wbd;
            tick;
            wb_we = 1'b0;
            a = act;
            e = vt[i].exp;
            if (!vt[i].has_imm) a.imm = e.imm;
            if (vt[i].full) ok = (a == e);
            else ok = (a.valid == e.valid) && (a.fl == e.fl)
                      && (a.pc == e.pc);
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL vec%0d: got %h want %h", i, a, e);
            end
        end

        // load-use: lw x9,0(x1) then add x10,x9,x9
        drive(1'b1, 32'h0000A483, 32'h0000_2000);
        tick;
        chk("lw_memrd", {26'd0, ex_mem_rd, ex_rd}, {26'd0, 1'b1, 5'd9});
        drive(1'b1, 32'h00948533, 32'h0000_2004);
        #1;
        chk("lu_stall", {31'd0, stall_o}, 32'd1);
        tick;
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        chk("lu_unstall", {31'd0, stall_o}, 32'd0);
        tick;
        chk("lu_add", {26'd0, ex_valid, ex_rd}, {26'd0, 1'b1, 5'd10});

        // flush beats en=0
        drive(1'b1, 32'hFE208CE3, 32'h0000_3000);
        en = 1'b0; flush = 1'b1;
        tick;
        chk("flush_valid", {30'd0, ex_valid, ex_branch}, 32'd0);
        en = 1'b1; flush = 1'b0;
        tick;
        chk("beq_imm", ex_imm, 32'hFFFFFFF8);
        chk("beq_ctl", {24'd0, ex_valid, ex_alu_op, ex_branch, ex_jump,
                        ex_reg_wr}, {24'd0, 1'b1, 4'd1, 3'b100});

        // x0 writes ignored, also through the bypass path
        drive(1'b1, 32'h000007B3, 32'h0000_3100);
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
        tick;
        wb_we = 1'b0;
        chk("x0_bypass", ex_rs1_val, 32'd0);
        tick;
        chk("x0_read", ex_rs1_val | ex_rs2_val, 32'd0);

        // illegal instruction, then hold with en=0 while wb commits
        drive(1'b1, 32'hFFFFFFFF, 32'h0000_4000);
        tick;
        chk("ill_ctl", {24'd0, act.fl}, 32'h01);
        en = 1'b0;
        drive(1'b1, 32'h00028333, 32'h0000_4004);
        wb_we = 1'b1; wb_rd = 5'd20; wb_data = 32'h0000CAFE;
        for (int c = 0; c < 3; c++) begin
            tick;
            wb_we = 1'b0;
            chk($sformatf("hold%0d", c), {23'd0, ex_valid, act.fl},
                {23'd0, 1'b1, 8'h01});
            chk($sformatf("hold%0d_pc", c), ex_pc, 32'h0000_4000);
        end
        en = 1'b1;
        drive(1'b1, 32'h000A0AB3, 32'h0000_4008);
        tick;
        chk("wb_in_hold", ex_rs1_val, 32'h0000CAFE);

        // reset mid-run clears pipeline and register file
        rst_n = 1'b0;
        drive(1'b1, 32'h00028333, 32'h0000_5000);
        tick;
        chk("rst2_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst2_pc", ex_pc, RST_PC);
        rst_n = 1'b1;
        tick;
        chk("rst2_x5", ex_rs1_val, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
